// File: rtl/video_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// video_fetch_arbiter
//   Aging-priority arbiter issuing one AXI INCR read burst at a time.
//   Rev 1.0
// ============================================================================
module video_fetch_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int AGE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_len,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [7:0]            rsp_index,
  output logic [31:0]           rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  protocol_err,
  output logic                  axi_ar_valid,
  input  logic                  axi_ar_ready,
  output logic [31:0]           axi_ar_payload_addr,
  output logic [7:0]            axi_ar_payload_len,
  output logic [1:0]            axi_ar_payload_burst,
  input  logic                  axi_r_valid,
  output logic                  axi_r_ready,
  input  logic [31:0]           axi_r_payload_data,
  input  logic                  axi_r_payload_last
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic                            ar_valid_q, ar_valid_d;
  logic [31:0]                     addr_q, addr_d;
  logic [7:0]                      len_q, len_d;
  logic [1:0]                      id_q, id_d;
  logic [7:0]                      beat_q, beat_d;
  logic                            err_q, err_d;
  logic [NUM_REQ-1:0][AGE_W-1:0]   age_q, age_d;

  logic [NUM_REQ-1:0] aged;
  logic [NUM_REQ-1:0] grant;
  logic               any_aged;
  logic               grant_any;
  logic [1:0]         grant_id;
  logic [31:0]        sel_addr;
  logic [7:0]         sel_len;
  logic               r_fire;

  // Aged requesters form their own priority tier; otherwise plain fixed priority.
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      aged[i] = req_valid[i] && (age_q[i] == AGE_W'(AGE_LIMIT));
    end
    any_aged = |aged;
    grant_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (any_aged ? aged[i] : req_valid[i]) begin
        grant_id = 2'(i);
      end
    end
    grant_any = (|req_valid) && (state_q == S_IDLE) && !reset;
    grant     = '0;
    sel_addr  = '0;
    sel_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        grant[i] = grant_any;
        sel_addr = req_addr[i*32 +: 32];
        sel_len  = req_len[i*8 +: 8];
      end
    end
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || grant[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_W'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  assign r_fire = axi_r_valid && axi_r_ready;

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    beat_d     = beat_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          addr_d     = sel_addr;
          len_d      = sel_len;
          id_d       = grant_id;
          beat_d     = '0;
          ar_valid_d = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ar_valid_q && axi_ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (r_fire) begin
          beat_d = beat_q + 8'd1;
          // A short burst or an overrun is flagged, but last always ends the burst.
          if (axi_r_payload_last) begin
            if (beat_q != len_q) err_d = 1'b1;
            state_d = S_IDLE;
          end else if (beat_q == len_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ar_valid_q <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      age_q      <= '0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    id_q   <= id_d;
  end

  assign req_ready            = grant;
  assign axi_ar_valid         = ar_valid_q;
  assign axi_ar_payload_addr  = addr_q;
  assign axi_ar_payload_len   = len_q;
  assign axi_ar_payload_burst = 2'd1;
  assign axi_r_ready          = (state_q == S_DATA);
  assign rsp_valid            = r_fire;
  assign rsp_id               = id_q;
  assign rsp_index            = beat_q;
  assign rsp_data             = axi_r_payload_data;
  assign rsp_last             = axi_r_payload_last;
  assign busy                 = (state_q != S_IDLE);
  assign protocol_err         = err_q;

endmodule
`default_nettype wire
